// File: rtl/neuron_pkg.sv
// ============================================================================
// neuron_pkg -- shared types and constants for the spiking-neuron datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

package neuron_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] SAT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRE   = 2'd1,
    ST_REFRAC = 2'd2
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_add8.sv
// ============================================================================
// sat_add8 -- 8-bit unsigned adder that clamps at the saturation maximum
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_add8
  import neuron_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y   = sum[DATA_W] ? SAT_MAX : sum[DATA_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/spike_gen.sv
// ============================================================================
// spike_gen -- threshold spike generator with refractory period, adaptive
//              threshold and saturating spike counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module spike_gen
  import neuron_pkg::*;
#(
  parameter int REFRAC_CYCLES = 3,
  parameter int THRESH_INC    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] state,
  input  logic [DATA_W-1:0] threshold_base,
  input  logic              enable,
  input  logic              count_clr,
  output logic              spike,
  output logic              refractory,
  output logic [DATA_W-1:0] threshold_eff,
  output logic [DATA_W-1:0] spike_count
);

  localparam logic [3:0]        REFRAC_LOAD = 4'(REFRAC_CYCLES - 1);
  localparam logic [DATA_W-1:0] INC_VAL     = 8'(THRESH_INC);

  fsm_state_t        fsm_q, fsm_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] adapt_q, adapt_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              spike_q, spike_d;
  logic              refrac_q, refrac_d;

  logic [DATA_W-1:0] adapt_inc;
  logic [DATA_W-1:0] count_inc;
  logic              fire;

  sat_add8 u_thr_add (
    .a (threshold_base),
    .b (adapt_q),
    .y (threshold_eff)
  );

  sat_add8 u_adapt_add (
    .a (adapt_q),
    .b (INC_VAL),
    .y (adapt_inc)
  );

  sat_add8 u_count_add (
    .a (count_q),
    .b (8'd1),
    .y (count_inc)
  );

  assign fire = (fsm_q == ST_IDLE) && enable && (state >= threshold_eff);

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    adapt_d = adapt_q;
    count_d = count_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (fire) begin
          fsm_d   = ST_FIRE;
          adapt_d = adapt_inc;
          count_d = count_inc;
        end else if (adapt_q != '0) begin
          adapt_d = adapt_q - 8'd1;
        end
      end
      ST_FIRE: begin
        fsm_d = ST_REFRAC;
        cnt_d = REFRAC_LOAD;
      end
      ST_REFRAC: begin
        if (cnt_q == 4'd0) begin
          fsm_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
    // A clear coinciding with a fire edge still counts that spike
    if (count_clr) begin
      count_d = fire ? 8'd1 : 8'd0;
    end
    spike_d  = (fsm_d == ST_FIRE);
    refrac_d = (fsm_d == ST_REFRAC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= ST_IDLE;
      cnt_q    <= '0;
      adapt_q  <= '0;
      count_q  <= '0;
      spike_q  <= 1'b0;
      refrac_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      adapt_q  <= adapt_d;
      count_q  <= count_d;
      spike_q  <= spike_d;
      refrac_q <= refrac_d;
    end
  end

  assign spike       = spike_q;
  assign refractory  = refrac_q;
  assign spike_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_spike_gen.sv
// ============================================================================
// tb_spike_gen -- randomized and directed bench for spike_gen against a
//                 cycle-budget behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spike_gen;

  localparam int R   = 3;
  localparam int INC = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] state = 8'd0;
  logic [7:0] threshold_base = 8'd0;
  logic       enable = 1'b0;
  logic       count_clr = 1'b0;
  logic       spike;
  logic       refractory;
  logic [7:0] threshold_eff;
  logic [7:0] spike_count;

  int total = 0;
  int bad   = 0;

  // Model: busy = cycles still owed to the fire pulse plus refractory period
  int m_busy  = 0;
  int m_adapt = 0;
  int m_count = 0;

  spike_gen #(.REFRAC_CYCLES(R), .THRESH_INC(INC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .state          (state),
    .threshold_base (threshold_base),
    .enable         (enable),
    .count_clr      (count_clr),
    .spike          (spike),
    .refractory     (refractory),
    .threshold_eff  (threshold_eff),
    .spike_count    (spike_count)
  );

  always #5 clk = ~clk;

  function automatic int min255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic exp_spike();
    return (m_busy == R + 1);
  endfunction

  function automatic logic exp_ref();
    return (m_busy > 0) && (m_busy <= R);
  endfunction

  function automatic logic [7:0] exp_thr();
    return 8'(min255(int'(threshold_base) + m_adapt));
  endfunction

  task automatic model_edge();
    bit fire;
    int thr;
    fire = 1'b0;
    if (!reset_n) begin
      m_busy = 0; m_adapt = 0; m_count = 0;
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      thr = min255(int'(threshold_base) + m_adapt);
      if (enable && int'(state) >= thr) begin
        fire    = 1'b1;
        m_busy  = R + 1;
        m_adapt = min255(m_adapt + INC);
        m_count = min255(m_count + 1);
      end else if (m_adapt > 0) begin
        m_adapt--;
      end
    end
    if (count_clr) m_count = fire ? 1 : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    count_clr = 1'b0;
    m_busy = 0; m_adapt = 0; m_count = 0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    threshold_base = 8'd77;
    #1;
    total++;
    if ({spike, refractory} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got=%b want=00", {spike, refractory});
    end
    total++;
    if (threshold_eff !== 8'd77) begin
      bad++; $display("FAIL reset_thr got=%0d want=77", threshold_eff);
    end
    total++;
    if (spike_count !== 8'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", spike_count);
    end
  endtask

  task automatic test_threshold();
    do_reset();
    threshold_base = 8'd100; enable = 1'b1; state = 8'd99;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (spike !== 1'b0) begin
        bad++; $display("FAIL below_thr cyc=%0d spike got=%b want=0", i, spike);
      end
    end
    state = 8'd100;
    step();
    total++;
    if (spike !== 1'b1) begin
      bad++; $display("FAIL at_thr spike got=%b want=1", spike);
    end
    total++;
    if (threshold_eff !== 8'd116) begin
      bad++; $display("FAIL adapt_thr got=%0d want=116", threshold_eff);
    end
    for (int i = 0; i < R; i++) begin
      step();
      total++;
      if ({spike, refractory} !== 2'b01) begin
        bad++; $display("FAIL refrac cyc=%0d got=%b want=01", i, {spike, refractory});
      end
    end
    state = 8'd0;
    step();
    total++;
    if ({spike, refractory} !== 2'b00) begin
      bad++; $display("FAIL refrac_end got=%b want=00", {spike, refractory});
    end
  endtask

  task automatic test_decay();
    do_reset();
    threshold_base = 8'd100; enable = 1'b1; state = 8'd255;
    step();
    state = 8'd0;
    for (int i = 0; i < R + 1; i++) step();
    total++;
    if (threshold_eff !== 8'd116) begin
      bad++; $display("FAIL decay_start got=%0d want=116", threshold_eff);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      total++;
      if (threshold_eff !== 8'((116 - i < 100) ? 100 : 116 - i)) begin
        bad++; $display("FAIL decay idle=%0d got=%0d want=%0d", i, threshold_eff,
                        (116 - i < 100) ? 100 : 116 - i);
      end
    end
  endtask

  task automatic test_saturation();
    int last;
    int ok_period;
    do_reset();
    threshold_base = 8'd100; enable = 1'b1; state = 8'd255;
    last = -1;
    for (int c = 0; c < 200; c++) begin
      step();
      total++;
      if (threshold_eff !== exp_thr()) begin
        bad++; $display("FAIL sat_thr cyc=%0d got=%0d want=%0d", c, threshold_eff, exp_thr());
      end
      if (spike === 1'b1) begin
        if (last >= 0) begin
          ok_period = c - last;
          total++;
          if (ok_period != R + 2) begin
            bad++; $display("FAIL period cyc=%0d got=%0d want=%0d", c, ok_period, R + 2);
          end
        end
        last = c;
      end
    end
    total++;
    if (threshold_eff !== 8'd255) begin
      bad++; $display("FAIL sat_final got=%0d want=255", threshold_eff);
    end
    total++;
    if (last < 190) begin
      bad++; $display("FAIL sat_spiking last_spike=%0d want>=190", last);
    end
  endtask

  task automatic test_count();
    int guard;
    do_reset();
    threshold_base = 8'd0; enable = 1'b1; state = 8'd255;
    for (int c = 0; c < 1600; c++) step();
    total++;
    if (spike_count !== 8'd255) begin
      bad++; $display("FAIL count_sat got=%0d want=255", spike_count);
    end
    guard = 0;
    while (m_busy != 0 && guard < 20) begin
      step(); guard++;
    end
    total++;
    if (m_busy != 0) begin
      bad++; $display("FAIL clr_wait timeout busy=%0d want=0", m_busy);
    end
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    total++;
    if ({spike, spike_count} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL clr_on_fire spike=%b count=%0d want spike=1 count=1", spike, spike_count);
    end
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    total++;
    if (spike_count !== 8'd0) begin
      bad++; $display("FAIL clr_busy got=%0d want=0", spike_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    threshold_base = 8'd100; enable = 1'b1; state = 8'd200;
    step(); step(); step();
    total++;
    if (refractory !== 1'b1) begin
      bad++; $display("FAIL pre_reset refractory got=%b want=1", refractory);
    end
    #2 reset_n = 1'b0;
    #1;
    m_busy = 0; m_adapt = 0; m_count = 0;
    total++;
    if ({spike, refractory} !== 2'b00) begin
      bad++; $display("FAIL async_flags got=%b want=00", {spike, refractory});
    end
    total++;
    if ({threshold_eff, spike_count} !== {8'd100, 8'd0}) begin
      bad++; $display("FAIL async_regs thr=%0d count=%0d want thr=100 count=0", threshold_eff, spike_count);
    end
    #1 reset_n = 1'b1;
    state = 8'd100;
    #1;
    total++;
    if (spike !== 1'b0) begin
      bad++; $display("FAIL post_release spike got=%b want=0", spike);
    end
    step();
    total++;
    if (spike !== 1'b1) begin
      bad++; $display("FAIL first_compare spike got=%b want=1", spike);
    end
  endtask

  task automatic test_enable();
    do_reset();
    threshold_base = 8'd100; enable = 1'b0; state = 8'd200;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (spike !== 1'b0) begin
        bad++; $display("FAIL disabled cyc=%0d spike got=%b want=0", i, spike);
      end
    end
    enable = 1'b1;
    step();
    total++;
    if (spike !== 1'b1) begin
      bad++; $display("FAIL enable_fire spike got=%b want=1", spike);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      threshold_base = 8'($urandom_range(0, 255));
      state          = 8'($urandom_range(0, 255));
      enable         = ($urandom_range(0, 3) != 0);
      count_clr      = ($urandom_range(0, 15) == 0);
      step();
      total++;
      if ({spike, refractory} !== {exp_spike(), exp_ref()}) begin
        bad++; $display("FAIL rnd_flags cyc=%0d got=%b want=%b", c, {spike, refractory}, {exp_spike(), exp_ref()});
      end
      total++;
      if (threshold_eff !== exp_thr()) begin
        bad++; $display("FAIL rnd_thr cyc=%0d got=%0d want=%0d", c, threshold_eff, exp_thr());
      end
      total++;
      if (spike_count !== 8'(m_count)) begin
        bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", c, spike_count, m_count);
      end
    end
    count_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_decay();
    test_saturation();
    test_count();
    test_async_reset();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
